// File: rtl/fp_special_pipe_if.sv
// Operand bus into and result bus out of the FP special-value pipeline.
// master: upstream/downstream side (drives input beat and out_ready).
// slave : the pipeline (drives in_ready, out_valid, class flags, result).
interface fp_special_pipe_if #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned MANT_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;

  logic              out_valid;
  logic              out_ready;
  logic              is_nan;
  logic              is_snan;
  logic              is_pinf;
  logic              is_ninf;
  logic              is_zero;
  logic              is_normal;
  logic              is_subnormal;
  logic              sign_out;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mant_out;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, is_nan, is_snan, is_pinf, is_ninf,
           is_zero, is_normal, is_subnormal, sign_out, exp_out, mant_out
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, is_nan, is_snan, is_pinf, is_ninf,
           is_zero, is_normal, is_subnormal, sign_out, exp_out, mant_out
  );
endinterface

// File: rtl/fp_special_pipe.sv
// Two-stage special-value classifier for a parametrised IEEE-style float.
// Classifies the input, optionally flushes subnormals (daz) and canonicalises
// NaNs, and keeps saturating NaN / subnormal output-event counters.
// Ports:
//   clk, rst          clock, async active-high reset
//   enable            global stall (0 freezes everything)
//   daz, canon_nan    per-beat modes, sampled with the input handshake
//   cnt_clr           synchronous clear of both counters (beats increments)
//   bus               operand in / result out with valid-ready handshakes
//   cnt_nan, cnt_sub  saturating event counters
module fp_special_pipe #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned MANT_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               daz,
  input  logic               canon_nan,
  input  logic               cnt_clr,
  fp_special_pipe_if.slave   bus,
  output logic [CNT_W-1:0]   cnt_nan,
  output logic [CNT_W-1:0]   cnt_sub
);

  typedef struct packed {
    logic              is_nan;
    logic              is_snan;
    logic              is_pinf;
    logic              is_ninf;
    logic              is_zero;
    logic              is_normal;
    logic              is_sub;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } beat_t;

  beat_t             cls;
  beat_t             s1_q, s1_d, s2_q, s2_d;
  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [CNT_W-1:0]  cnt_nan_q, cnt_nan_d, cnt_sub_q, cnt_sub_d;
  logic              e1, e0, m0;
  logic              adv1, adv2, out_hs;

  // Classification and result data of the incoming beat.
  always_comb begin
    e1  = &bus.in_exp;
    e0  = ~|bus.in_exp;
    m0  = ~|bus.in_mant;
    cls = '0;
    cls.sign      = bus.in_sign;
    cls.exp       = bus.in_exp;
    cls.mant      = bus.in_mant;
    cls.is_nan    = e1 & ~m0;
    cls.is_snan   = e1 & ~m0 & ~bus.in_mant[MANT_W-1];
    cls.is_pinf   = e1 & m0 & ~bus.in_sign;
    cls.is_ninf   = e1 & m0 & bus.in_sign;
    cls.is_zero   = e0 & m0;
    cls.is_sub    = e0 & ~m0;
    cls.is_normal = ~e1 & ~e0;
    if (e1 & ~m0) begin
      // Quieting keeps the payload; canonical form drops sign and payload.
      if (canon_nan) begin
        cls.sign = 1'b0;
        cls.exp  = '1;
        cls.mant = '0;
      end
      cls.mant[MANT_W-1] = 1'b1;
    end else if (e0 & ~m0 & daz) begin
      // Flags still report subnormal: they describe the input, not the result.
      cls.exp  = '0;
      cls.mant = '0;
    end
  end

  // Pipeline advance, stage loads and counter updates.
  always_comb begin
    adv2       = enable & (~s2_valid_q | bus.out_ready);
    adv1       = enable & (~s1_valid_q | adv2);
    out_hs     = enable & s2_valid_q & bus.out_ready;
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    cnt_nan_d  = cnt_nan_q;
    cnt_sub_d  = cnt_sub_q;
    if (adv1) begin
      s1_d       = cls;
      s1_valid_d = bus.in_valid;
    end
    if (adv2) begin
      s2_d       = s1_q;
      s2_valid_d = s1_valid_q;
    end
    if (enable & cnt_clr) begin
      cnt_nan_d = '0;
      cnt_sub_d = '0;
    end else if (out_hs) begin
      if (s2_q.is_nan && cnt_nan_q != '1) cnt_nan_d = cnt_nan_q + CNT_W'(1);
      if (s2_q.is_sub && cnt_sub_q != '1) cnt_sub_d = cnt_sub_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
      cnt_nan_q  <= '0;
      cnt_sub_q  <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
      cnt_nan_q  <= cnt_nan_d;
      cnt_sub_q  <= cnt_sub_d;
    end
  end

  // Handshake outputs; ready is held low while reset is asserted.
  assign bus.in_ready     = adv1 & ~rst;
  assign bus.out_valid    = s2_valid_q & enable;
  assign bus.is_nan       = s2_q.is_nan;
  assign bus.is_snan      = s2_q.is_snan;
  assign bus.is_pinf      = s2_q.is_pinf;
  assign bus.is_ninf      = s2_q.is_ninf;
  assign bus.is_zero      = s2_q.is_zero;
  assign bus.is_normal    = s2_q.is_normal;
  assign bus.is_subnormal = s2_q.is_sub;
  assign bus.sign_out     = s2_q.sign;
  assign bus.exp_out      = s2_q.exp;
  assign bus.mant_out     = s2_q.mant;
  assign cnt_nan          = cnt_nan_q;
  assign cnt_sub          = cnt_sub_q;

endmodule

// File: tb/tb_fp_special_pipe.sv
// Bench for fp_special_pipe: FP16 instance with 16-bit counters plus a
// twin with 2-bit counters fed the same stimulus; a queue-based reference
// model predicts every output beat and both counter pairs.
module tb_fp_special_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        daz = 1'b0;
  logic        canon_nan = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [4:0]  in_exp = '0;
  logic [9:0]  in_mant = '0;
  logic        out_ready = 1'b1;
  logic [15:0] a_cnt_nan, a_cnt_sub;
  logic [1:0]  b_cnt_nan, b_cnt_sub;

  fp_special_pipe_if #(.EXP_W(5), .MANT_W(10)) ia ();
  fp_special_pipe_if #(.EXP_W(5), .MANT_W(10)) ib ();

  assign ia.in_valid = in_valid;  assign ib.in_valid = in_valid;
  assign ia.in_sign  = in_sign;   assign ib.in_sign  = in_sign;
  assign ia.in_exp   = in_exp;    assign ib.in_exp   = in_exp;
  assign ia.in_mant  = in_mant;   assign ib.in_mant  = in_mant;
  assign ia.out_ready = out_ready; assign ib.out_ready = out_ready;

  fp_special_pipe #(.EXP_W(5), .MANT_W(10), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .daz(daz), .canon_nan(canon_nan),
    .cnt_clr(cnt_clr), .bus(ia), .cnt_nan(a_cnt_nan), .cnt_sub(a_cnt_sub));

  fp_special_pipe #(.EXP_W(5), .MANT_W(10), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .daz(daz), .canon_nan(canon_nan),
    .cnt_clr(cnt_clr), .bus(ib), .cnt_nan(b_cnt_nan), .cnt_sub(b_cnt_sub));

  always #5 clk = ~clk;

  logic [6:0]  flags_a, flags_b;
  logic [15:0] data_a, data_b;
  assign flags_a = {ia.is_nan, ia.is_snan, ia.is_pinf, ia.is_ninf,
                    ia.is_zero, ia.is_normal, ia.is_subnormal};
  assign flags_b = {ib.is_nan, ib.is_snan, ib.is_pinf, ib.is_ninf,
                    ib.is_zero, ib.is_normal, ib.is_subnormal};
  assign data_a  = {ia.sign_out, ia.exp_out, ia.mant_out};
  assign data_b  = {ib.sign_out, ib.exp_out, ib.mant_out};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected beat: flags {nan,snan,pinf,ninf,zero,normal,sub}, FP16 result,
  // and the cycle the input was accepted.
  typedef struct {
    logic [6:0]  f;
    logic [15:0] d;
    int          c;
  } exp_t;

  function automatic exp_t model(input logic [15:0] x, input logic dz, input logic cn, input int c);
    exp_t r;
    int e, m;
    e = (int'(x) / 1024) % 32;
    m = int'(x) % 1024;
    r.c = c;
    r.d = x;
    if (e == 31 && m != 0) begin
      r.f = (m < 512) ? 7'b1100000 : 7'b1000000;
      r.d = cn ? 16'h7E00 : (x | 16'h0200);
    end else if (e == 31) begin
      r.f = (x >= 16'h8000) ? 7'b0001000 : 7'b0010000;
    end else if (e == 0 && m == 0) begin
      r.f = 7'b0000100;
    end else if (e == 0) begin
      r.f = 7'b0000001;
      if (dz) r.d = x & 16'h8000;
    end else begin
      r.f = 7'b0000010;
    end
    return r;
  endfunction

  exp_t q[$];
  int   cyc = 0;
  int   mn16 = 0, ms16 = 0, mn2 = 0, ms2 = 0;
  bit   lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard, sampled mid-cycle: predicts what the next edge will do.
  always @(negedge clk) begin
    exp_t e;
    bit   hs_nan, hs_sub;
    if (rst) begin
      q.delete();
      mn16 = 0; ms16 = 0; mn2 = 0; ms2 = 0;
    end else begin
      check("cnt_nan", 64'(a_cnt_nan), 64'(mn16));
      check("cnt_sub", 64'(a_cnt_sub), 64'(ms16));
      check("cnt_nan_w2", 64'(b_cnt_nan), 64'(mn2));
      check("cnt_sub_w2", 64'(b_cnt_sub), 64'(ms2));
      hs_nan = 1'b0;
      hs_sub = 1'b0;
      if (ia.out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'(1), 64'(0));
        end else begin
          e = q[0];
          check("flags", 64'(flags_a), 64'(e.f));
          check("data", 64'(data_a), 64'(e.d));
          check("flags_w2", 64'(flags_b), 64'(e.f));
          check("data_w2", 64'(data_b), 64'(e.d));
          if (lat_chk) check("latency", 64'(cyc - e.c), 64'(2));
          if (out_ready) begin
            void'(q.pop_front());
            hs_nan = e.f[6];
            hs_sub = e.f[0];
          end
        end
      end
      if (enable && cnt_clr) begin
        mn16 = 0; ms16 = 0; mn2 = 0; ms2 = 0;
      end else begin
        if (hs_nan && mn16 < 65535) mn16++;
        if (hs_sub && ms16 < 65535) ms16++;
        if (hs_nan && mn2 < 3) mn2++;
        if (hs_sub && ms2 < 3) ms2++;
      end
      if (in_valid && ia.in_ready)
        q.push_back(model({in_sign, in_exp, in_mant}, daz, canon_nan, cyc));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic dz, input logic cn);
    bit ok = 1'b0;
    in_valid  = 1'b1;
    in_sign   = x[15];
    in_exp    = x[14:10];
    in_mant   = x[9:0];
    daz       = dz;
    canon_nan = cn;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ia.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("drain", 64'(ok), 64'(1));
  endtask

  logic [15:0] rx;
  bit          done;

  initial begin
    #3;
    check("rst_in_ready", 64'(ia.in_ready), 64'(0));
    check("rst_out_valid", 64'(ia.out_valid), 64'(0));
    check("rst_flags", 64'(flags_a), 64'(0));
    check("rst_data", 64'(data_a), 64'(0));
    check("rst_cnts", 64'({a_cnt_nan, a_cnt_sub}), 64'(0));
    idle(2);
    rst = 1'b0;

    // Back-to-back class stream, fixed 2-cycle latency.
    lat_chk = 1'b1;
    send(16'h3C00, 0, 0);
    send(16'h0000, 0, 0);
    send(16'h8001, 0, 0);
    send(16'hFC00, 0, 0);
    send(16'h7C00, 0, 0);
    idle(3);
    check("cnt_sub_stream", 64'(a_cnt_sub), 64'(1));

    // sNaN quieting and canonicalisation, then DAZ flush.
    send(16'h7C01, 0, 0);
    send(16'h7C01, 0, 1);
    idle(3);
    check("cnt_nan_two", 64'(a_cnt_nan), 64'(2));
    send(16'h8001, 1, 0);
    idle(3);
    check("cnt_sub_daz", 64'(a_cnt_sub), 64'(2));
    lat_chk = 1'b0;

    // Backpressure: two beats held, third waits.
    out_ready = 1'b0;
    send(16'h3C00, 0, 0);
    send(16'h4000, 0, 0);
    fork
      send(16'h4400, 0, 0);
      begin
        idle(2);
        check("bp_in_ready", 64'(ia.in_ready), 64'(0));
        check("bp_out_valid", 64'(ia.out_valid), 64'(1));
        check("bp_hold", 64'(data_a), 64'(16'h3C00));
        idle(1);
        check("bp_hold2", 64'(data_a), 64'(16'h3C00));
        out_ready = 1'b1;
      end
    join
    drain();

    // Global stall mid-stream.
    fork
      begin
        send(16'h3555, 0, 0);
        send(16'h7C02, 0, 0);
        send(16'h0200, 0, 0);
        send(16'hC000, 0, 0);
      end
      begin
        idle(1);
        enable = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
          check("stall_in_ready", 64'(ia.in_ready), 64'(0));
          check("stall_out_valid", 64'(ia.out_valid), 64'(0));
          idle(1);
        end
        enable = 1'b1;
      end
    join
    drain();

    // Saturation on the 2-bit counters, then clear-vs-increment priority.
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    check("clr_cnt_nan", 64'(a_cnt_nan), 64'(0));
    for (int i = 0; i < 5; i++) send(16'h7E00 | 16'(i), 0, 1'(i % 2));
    idle(3);
    check("sat_w2", 64'(b_cnt_nan), 64'(3));
    check("sat_w16", 64'(a_cnt_nan), 64'(5));
    send(16'h7D00, 0, 0);
    idle(1);
    check("clr_hs_valid", 64'(ia.out_valid), 64'(1));
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    check("clr_prio", 64'(a_cnt_nan), 64'(0));
    check("clr_prio_w2", 64'(b_cnt_nan), 64'(0));

    // Randomised traffic with random stalls, backpressure and clears.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          rx = 16'($urandom);
          case ($urandom % 4)
            0: rx[14:10] = 5'h1F;
            1: rx[14:10] = 5'h00;
            default: ;
          endcase
          if ($urandom % 4 == 0) rx[9:0] = '0;
          send(rx, 1'($urandom % 2), 1'($urandom % 2));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom % 4) != 0;
          enable    = ($urandom % 8) != 0;
          cnt_clr   = ($urandom % 64) == 0;
        end
        out_ready = 1'b1;
        enable    = 1'b1;
        cnt_clr   = 1'b0;
      end
    join
    drain();

    // Reset asserted with beats in flight.
    send(16'h0001, 0, 0);
    send(16'h7C01, 0, 0);
    check("pre_rst_valid", 64'(ia.out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(ia.out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(ia.in_ready), 64'(0));
    check("mid_rst_flags", 64'(flags_a), 64'(0));
    check("mid_rst_data", 64'(data_a), 64'(0));
    check("mid_rst_cnts", 64'({a_cnt_nan, a_cnt_sub}), 64'(0));
    idle(2);
    rst = 1'b0;
    idle(3);
    check("post_rst_out_valid", 64'(ia.out_valid), 64'(0));
    check("post_rst_cnt_sub", 64'(a_cnt_sub), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    check("global_timeout", 64'(0), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_special_pipe.md
Name: fp_special_pipe

Overview:
- Parametrised successor to the FP16 special-value stage: classifies an IEEE-style float of any exponent/mantissa width.
- Applies optional denormals-are-zero (DAZ) flushing and NaN canonicalisation.
- Uses a 2-stage pipeline with full valid/ready backpressure instead of a single capture register.
- Sits between operand unpack and the arithmetic datapath; also keeps saturating NaN/subnormal event counters for debug.

Parameters:
- EXP_W, 5, exponent width (must be >= 2).
- MANT_W, 10, mantissa width (must be >= 2).
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  global stall; 0 freezes the whole block.
- daz  in  1  flush subnormal inputs to signed zero; sampled with in_valid&in_ready.
- canon_nan  in  1  emit a canonical qNaN for any NaN; sampled with the data.
- cnt_clr  in  1  synchronous clear of both counters.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_sign  in  1  input sign bit.
- in_exp  in  EXP_W  input exponent.
- in_mant  in  MANT_W  input mantissa.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- is_nan, is_snan, is_pinf, is_ninf, is_zero, is_normal, is_subnormal  out  1 each  input class flags.
- sign_out  out  1  result sign.
- exp_out  out  EXP_W  result exponent.
- mant_out  out  MANT_W  result mantissa.
- cnt_nan  out  CNT_W  saturating count of NaN outputs.
- cnt_sub  out  CNT_W  saturating count of subnormal outputs.

Behaviour:
- Reset (async, rst=1): both stage valids 0, all flags/data outputs 0, counters 0, out_valid 0; in_ready is 0 while rst is high.
- Classification (on the input fields):
  - E1 = exp all-ones; E0 = exp zero; M0 = mant zero; Q = mant[MANT_W-1].
  - nan = E1 & ~M0; snan = nan & ~Q.
  - pinf = E1 & M0 & ~sign; ninf = E1 & M0 & sign.
  - zero = E0 & M0; subnormal = E0 & ~M0; normal = otherwise.
  - When out_valid=1, exactly one of {nan, pinf, ninf, zero, normal, subnormal} is 1; snan implies nan.
- Result data (computed in stage 1):
  - NaN with canon_nan=1: sign 0, exp all-ones, mant = 1<<(MANT_W-1).
  - NaN with canon_nan=0: sign and exp unchanged, mant with MSB forced to 1 (sNaN quieted, payload kept).
  - Subnormal with daz=1: sign kept, exp 0, mant 0. is_subnormal stays 1 and is_zero stays 0, because the flags describe the input.
  - All other cases: pass-through.
- Pipeline:
  - Stage S1 registers the classification and result; stage S2 is the output register.
  - adv2 = enable & (~s2_valid | out_ready); adv1 = enable & (~s1_valid | adv2); in_ready = adv1.
  - On adv1, S1 loads the input and s1_valid <= in_valid.
  - On adv2, S2 loads S1 and s2_valid <= s1_valid.
  - out_valid = s2_valid & enable.
- Latency: 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 beat/cycle with out_ready held high.
- Backpressure: while out_valid=1 and out_ready=0, all outputs hold stable. S1 still fills if empty, so up to 2 beats are held; in_ready drops only when both stages are full and stalled.
- enable=0: no register updates, in_ready=0, out_valid=0, counters hold. Held data reappears unchanged when enable returns to 1.
- Counters:
  - Increment on an output handshake (out_valid & out_ready): cnt_nan when is_nan, cnt_sub when is_subnormal.
  - Both saturate at all-ones (no wrap).
  - cnt_clr has priority: a clear and an increment in the same cycle yield 0.
- Reset asserted mid-stream: in-flight beats are discarded and nothing is counted.

Test Plan:
- FP16 defaults, out_ready=1, stream 0x3C00, 0x0000, 0x8001, 0xFC00, 0x7C00 on back-to-back cycles.
  - Required: flags appear 2 cycles after each handshake.
  - normal / zero / subnormal / ninf / pinf respectively.
  - Data unchanged; cnt_sub=1.
- 0x7C01 (sNaN) with canon_nan=0 → is_nan=1, is_snan=1, output 0x7E01. Same input with canon_nan=1 → output 0x7E00. cnt_nan=2.
- 0x8001 with daz=1 → is_subnormal=1, is_zero=0, output 0x8000.
- Hold out_ready=0 and feed 3 beats.
  - Required: out_valid=1 with the first beat held stable; in_ready=0 after 2 beats are accepted.
  - Release out_ready: beats emerge in order, none lost or duplicated.
- Toggle enable=0 mid-stream for 3 cycles → in_ready=0, out_valid=0, no state change; resumes identically.
- CNT_W=2: 5 NaN handshakes → cnt_nan=3 (saturated). Then cnt_clr together with a NaN handshake → cnt_nan=0. Assert rst mid-stream → all outputs 0 immediately.
